// File: rtl/fft_sample_buffer.sv
// Ping-pong frame buffer feeding fft_top: fills one bank while the FFT reads the other.
// Optional macro FFT_SAMPLE_BUFFER_OVERRUN_COUNT_EN adds a saturating dropped-sample counter.
module fft_sample_buffer #(
  parameter int DATA_WIDTH = 24,
  parameter int N_POINTS   = 512,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] i_sample,
  input  logic                  i_sample_valid,
  output logic                  o_buffer_data_ready,
  input  logic [ADDR_WIDTH-1:0] i_buffer_read_addr,
  output logic [DATA_WIDTH-1:0] o_buffer_data,
  input  logic                  i_fft_busy,
  input  logic                  i_fft_done_pulse,
  output logic                  o_overrun,
  output logic                  o_write_bank
`ifdef FFT_SAMPLE_BUFFER_OVERRUN_COUNT_EN
  ,
  output logic [15:0]           o_overrun_count
`endif
);

  typedef enum logic [1:0] {IDLE, READY, ACTIVE} state_t;

  state_t                  state_reg, state_next;
  logic                    wr_bank_reg;
  logic [ADDR_WIDTH-1:0]   wr_ptr_reg;
  logic                    wr_full_reg;
  logic                    overrun_reg;
  logic [DATA_WIDTH-1:0]   rd_data_reg;
  logic                    swap;
  logic                    write_en;
  logic                    drop;

  // Both banks live in one array; the bank index is the top address bit.
  logic [DATA_WIDTH-1:0]   mem [0:2*N_POINTS-1];

  assign write_en = reset && i_sample_valid && !wr_full_reg;
  assign drop     = i_sample_valid && wr_full_reg;

  always_comb begin
    state_next = state_reg;
    swap       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (wr_full_reg) begin
          swap       = 1'b1;
          state_next = READY;
        end
      end
      READY: begin
        if (i_fft_busy) state_next = ACTIVE;
      end
      ACTIVE: begin
        if (i_fft_done_pulse) begin
          if (wr_full_reg) begin
            swap       = 1'b1;
            state_next = READY;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (write_en) mem[{wr_bank_reg, wr_ptr_reg}] <= i_sample;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg   <= IDLE;
      wr_bank_reg <= 1'b0;
      wr_ptr_reg  <= '0;
      wr_full_reg <= 1'b0;
      overrun_reg <= 1'b0;
      rd_data_reg <= '0;
    end else begin
      state_reg   <= state_next;
      rd_data_reg <= mem[{~wr_bank_reg, i_buffer_read_addr}];
      if (drop) overrun_reg <= 1'b1;
      // A swap only happens with the bank full, so it never races a write.
      if (swap) begin
        wr_bank_reg <= ~wr_bank_reg;
        wr_full_reg <= 1'b0;
      end else if (write_en) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
        if (wr_ptr_reg == ADDR_WIDTH'(N_POINTS - 1)) wr_full_reg <= 1'b1;
      end
    end
  end

`ifdef FFT_SAMPLE_BUFFER_OVERRUN_COUNT_EN
  logic [15:0] overrun_count_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      overrun_count_reg <= '0;
    end else if (drop && (overrun_count_reg != 16'hFFFF)) begin
      overrun_count_reg <= overrun_count_reg + 16'd1;
    end
  end

  assign o_overrun_count = overrun_count_reg;
`endif

  assign o_buffer_data_ready = (state_reg == READY);
  assign o_buffer_data       = rd_data_reg;
  assign o_overrun           = overrun_reg;
  assign o_write_bank        = wr_bank_reg;

endmodule

// File: tb/tb_fft_sample_buffer.sv
// Self-checking bench for fft_sample_buffer: frame fill, hand-off, overrun, done timing and reset.
// Read expectations are queued when an address is driven and popped when the data emerges.
module tb_fft_sample_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] i_sample;
  logic        i_sample_valid;
  logic        o_buffer_data_ready;
  logic [8:0]  i_buffer_read_addr;
  logic [23:0] o_buffer_data;
  logic        i_fft_busy;
  logic        i_fft_done_pulse;
  logic        o_overrun;
  logic        o_write_bank;
`ifdef FFT_SAMPLE_BUFFER_OVERRUN_COUNT_EN
  logic [15:0] o_overrun_count;
`endif

  int checks   = 0;
  int failures = 0;
  logic [23:0] exp_q[$];

  fft_sample_buffer dut (
    .clk                 (clk),
    .reset               (reset),
    .i_sample            (i_sample),
    .i_sample_valid      (i_sample_valid),
    .o_buffer_data_ready (o_buffer_data_ready),
    .i_buffer_read_addr  (i_buffer_read_addr),
    .o_buffer_data       (o_buffer_data),
    .i_fft_busy          (i_fft_busy),
    .i_fft_done_pulse    (i_fft_done_pulse),
    .o_overrun           (o_overrun),
    .o_write_bank        (o_write_bank)
`ifdef FFT_SAMPLE_BUFFER_OVERRUN_COUNT_EN
    ,
    .o_overrun_count     (o_overrun_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_samples(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      i_sample       = 24'(base + i);
      i_sample_valid = 1'b1;
      tick();
    end
    i_sample_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    checks += 4;
    if (o_buffer_data_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b expected=0", o_buffer_data_ready); end
    if (o_overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b expected=0", o_overrun); end
    if (o_write_bank !== 1'b0) begin failures++; $display("FAIL reset_bank got=%b expected=0", o_write_bank); end
    if (o_buffer_data !== 24'd0) begin failures++; $display("FAIL reset_data got=%0d expected=0", o_buffer_data); end
    reset = 1'b1;
    tick();
    $display("reset: ready=%b overrun=%b bank=%b", o_buffer_data_ready, o_overrun, o_write_bank);
  endtask

  task automatic test_fill_and_read();
    int addrs[3] = '{0, 255, 511};
    logic [23:0] exp;
    write_samples(0, 512);
    checks++;
    if (o_buffer_data_ready !== 1'b0) begin failures++; $display("FAIL fill_ready_early got=%b expected=0", o_buffer_data_ready); end
    tick();
    checks += 2;
    if (o_buffer_data_ready !== 1'b1) begin failures++; $display("FAIL fill_ready got=%b expected=1", o_buffer_data_ready); end
    if (o_write_bank !== 1'b1) begin failures++; $display("FAIL fill_bank got=%b expected=1", o_write_bank); end
    foreach (addrs[k]) begin
      exp_q.push_back(24'(addrs[k]));
      i_buffer_read_addr = 9'(addrs[k]);
      tick();
      exp = exp_q.pop_front();
      checks++;
      $display("fill_read addr=%0d data=%0d", addrs[k], o_buffer_data);
      if (o_buffer_data !== exp) begin failures++; $display("FAIL fill_read addr=%0d got=%0d expected=%0d", addrs[k], o_buffer_data, exp); end
    end
  endtask

  task automatic test_second_frame();
    int addrs[2] = '{0, 511};
    logic [23:0] exp;
    i_fft_busy = 1'b1;
    tick();
    checks++;
    if (o_buffer_data_ready !== 1'b0) begin failures++; $display("FAIL active_ready got=%b expected=0", o_buffer_data_ready); end
    write_samples(512, 512);
    tick();
    tick();
    checks++;
    if (o_buffer_data_ready !== 1'b0) begin failures++; $display("FAIL wait_done_ready got=%b expected=0", o_buffer_data_ready); end
    i_fft_busy       = 1'b0;
    i_fft_done_pulse = 1'b1;
    tick();
    i_fft_done_pulse = 1'b0;
    checks += 3;
    if (o_buffer_data_ready !== 1'b1) begin failures++; $display("FAIL second_ready got=%b expected=1", o_buffer_data_ready); end
    if (o_write_bank !== 1'b0) begin failures++; $display("FAIL second_bank got=%b expected=0", o_write_bank); end
    if (o_overrun !== 1'b0) begin failures++; $display("FAIL second_overrun got=%b expected=0", o_overrun); end
    foreach (addrs[k]) begin
      exp_q.push_back(24'(512 + addrs[k]));
      i_buffer_read_addr = 9'(addrs[k]);
      tick();
      exp = exp_q.pop_front();
      checks++;
      $display("second_read addr=%0d data=%0d", addrs[k], o_buffer_data);
      if (o_buffer_data !== exp) begin failures++; $display("FAIL second_read addr=%0d got=%0d expected=%0d", addrs[k], o_buffer_data, exp); end
    end
  endtask

  task automatic test_done_same_cycle();
    int addrs[2] = '{3, 510};
    logic [23:0] exp;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    write_samples(2000, 512);
    tick();
    i_fft_busy = 1'b1;
    tick();
    write_samples(3000, 512);
    checks++;
    if (o_buffer_data_ready !== 1'b0) begin failures++; $display("FAIL same_pre_ready got=%b expected=0", o_buffer_data_ready); end
    i_fft_busy       = 1'b0;
    i_fft_done_pulse = 1'b1;
    tick();
    i_fft_done_pulse = 1'b0;
    checks += 3;
    if (o_buffer_data_ready !== 1'b1) begin failures++; $display("FAIL same_ready got=%b expected=1", o_buffer_data_ready); end
    if (o_write_bank !== 1'b0) begin failures++; $display("FAIL same_bank got=%b expected=0", o_write_bank); end
    if (o_overrun !== 1'b0) begin failures++; $display("FAIL same_overrun got=%b expected=0", o_overrun); end
    foreach (addrs[k]) begin
      exp_q.push_back(24'(3000 + addrs[k]));
      i_buffer_read_addr = 9'(addrs[k]);
      tick();
      exp = exp_q.pop_front();
      checks++;
      $display("same_read addr=%0d data=%0d", addrs[k], o_buffer_data);
      if (o_buffer_data !== exp) begin failures++; $display("FAIL same_read addr=%0d got=%0d expected=%0d", addrs[k], o_buffer_data, exp); end
    end
  endtask

  task automatic test_done_in_ready();
    logic [23:0] exp;
    i_fft_done_pulse = 1'b1;
    tick();
    i_fft_done_pulse = 1'b0;
    tick();
    checks += 2;
    if (o_buffer_data_ready !== 1'b1) begin failures++; $display("FAIL ready_done_ready got=%b expected=1", o_buffer_data_ready); end
    if (o_write_bank !== 1'b0) begin failures++; $display("FAIL ready_done_bank got=%b expected=0", o_write_bank); end
    exp_q.push_back(24'(3000 + 7));
    i_buffer_read_addr = 9'd7;
    tick();
    exp = exp_q.pop_front();
    checks++;
    $display("ready_done_read addr=7 data=%0d", o_buffer_data);
    if (o_buffer_data !== exp) begin failures++; $display("FAIL ready_done_read got=%0d expected=%0d", o_buffer_data, exp); end
  endtask

  task automatic test_overrun();
    int addrs[3] = '{0, 100, 511};
    logic [23:0] exp;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    write_samples(0, 512);
    tick();
    i_fft_busy = 1'b1;
    write_samples(512, 518);
    checks++;
    if (o_overrun !== 1'b1) begin failures++; $display("FAIL overrun_flag got=%b expected=1", o_overrun); end
`ifdef FFT_SAMPLE_BUFFER_OVERRUN_COUNT_EN
    checks++;
    if (o_overrun_count !== 16'd6) begin failures++; $display("FAIL overrun_count got=%0d expected=6", o_overrun_count); end
`endif
    i_fft_busy       = 1'b0;
    i_fft_done_pulse = 1'b1;
    tick();
    i_fft_done_pulse = 1'b0;
    checks++;
    if (o_buffer_data_ready !== 1'b1) begin failures++; $display("FAIL overrun_ready got=%b expected=1", o_buffer_data_ready); end
    foreach (addrs[k]) begin
      exp_q.push_back(24'(512 + addrs[k]));
      i_buffer_read_addr = 9'(addrs[k]);
      tick();
      exp = exp_q.pop_front();
      checks++;
      $display("overrun_read addr=%0d data=%0d", addrs[k], o_buffer_data);
      if (o_buffer_data !== exp) begin failures++; $display("FAIL overrun_read addr=%0d got=%0d expected=%0d", addrs[k], o_buffer_data, exp); end
    end
  endtask

  task automatic test_reset_mid();
    int addrs[3] = '{0, 299, 511};
    logic [23:0] exp;
    write_samples(7000, 300);
    reset = 1'b0;
    tick();
    checks += 3;
    if (o_buffer_data_ready !== 1'b0) begin failures++; $display("FAIL mid_reset_ready got=%b expected=0", o_buffer_data_ready); end
    if (o_overrun !== 1'b0) begin failures++; $display("FAIL mid_reset_overrun got=%b expected=0", o_overrun); end
    if (o_write_bank !== 1'b0) begin failures++; $display("FAIL mid_reset_bank got=%b expected=0", o_write_bank); end
`ifdef FFT_SAMPLE_BUFFER_OVERRUN_COUNT_EN
    checks++;
    if (o_overrun_count !== 16'd0) begin failures++; $display("FAIL mid_reset_count got=%0d expected=0", o_overrun_count); end
`endif
    reset = 1'b1;
    write_samples(8000, 511);
    tick();
    tick();
    checks++;
    if (o_buffer_data_ready !== 1'b0) begin failures++; $display("FAIL partial_ready got=%b expected=0", o_buffer_data_ready); end
    write_samples(8511, 1);
    tick();
    checks++;
    if (o_buffer_data_ready !== 1'b1) begin failures++; $display("FAIL fresh_ready got=%b expected=1", o_buffer_data_ready); end
    foreach (addrs[k]) begin
      exp_q.push_back(24'(8000 + addrs[k]));
      i_buffer_read_addr = 9'(addrs[k]);
      tick();
      exp = exp_q.pop_front();
      checks++;
      $display("fresh_read addr=%0d data=%0d", addrs[k], o_buffer_data);
      if (o_buffer_data !== exp) begin failures++; $display("FAIL fresh_read addr=%0d got=%0d expected=%0d", addrs[k], o_buffer_data, exp); end
    end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    checks += 2;
    if (o_buffer_data_ready !== 1'b0) begin failures++; $display("FAIL ready_reset_ready got=%b expected=0", o_buffer_data_ready); end
    if (o_write_bank !== 1'b0) begin failures++; $display("FAIL ready_reset_bank got=%b expected=0", o_write_bank); end
  endtask

  initial begin
    reset              = 1'b0;
    i_sample           = '0;
    i_sample_valid     = 1'b0;
    i_buffer_read_addr = '0;
    i_fft_busy         = 1'b0;
    i_fft_done_pulse   = 1'b0;
    test_reset();
    test_fill_and_read();
    test_second_frame();
    test_done_same_cycle();
    test_done_in_ready();
    test_overrun();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
